// File: rtl/fetch_buffer.sv
// ---------------------------------------------------------------------------
// fetch_buffer
//
// Purpose:
//   Small circular FIFO sitting between instruction fetch and decode. Each
//   entry holds a {pc, instruction} pair. When the buffer is full the PC
//   register is told to hold via pc_update_n. A flush (redirect) empties the
//   buffer and drops any same-cycle incoming pair.
//
// Optional feature:
//   FETCH_BUF_BYPASS_EN - when defined, an incoming pair is forwarded
//   combinationally to the output while the buffer is empty. If decode takes
//   it in that same cycle it is never stored.
//
// Parameters:
//   WIDTH - PC width in bits (default 32)
//   DEPTH - number of entries, power of two, >= 2 (default 4)
//
// Ports:
//   clk          in   clock, all state updates on rising edge
//   reset_n      in   asynchronous active-low reset
//   in_valid     in   fetch pair valid this cycle
//   in_pc        in   [WIDTH-1:0] address of fetched instruction
//   in_instr     in   [31:0] fetched instruction word
//   pc_update_n  out  1 = PC holds (buffer full), 0 = PC advances
//   flush        in   redirect, discards buffered and incoming entries
//   out_valid    out  head entry valid for decode
//   out_pc       out  [WIDTH-1:0] PC of head entry
//   out_instr    out  [31:0] instruction of head entry
//   out_ready    in   decode accepts head entry this cycle
//   count        out  [$clog2(DEPTH):0] number of stored entries
// ---------------------------------------------------------------------------
module fetch_buffer #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     in_valid,
    input  logic [WIDTH-1:0]         in_pc,
    input  logic [31:0]              in_instr,
    output logic                     pc_update_n,
    input  logic                     flush,
    output logic                     out_valid,
    output logic [WIDTH-1:0]         out_pc,
    output logic [31:0]              out_instr,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [PW-1:0]    head_q, head_d;
    logic [PW-1:0]    tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] pc_mem_q    [DEPTH];
    logic [31:0]      instr_mem_q [DEPTH];

    // ------------------------------------------------------------------
    // Status
    // ------------------------------------------------------------------
    logic full;
    logic empty;
    logic stored_valid;
    logic push;
    logic pop;
    logic bypass_hit;
    logic bypass_take;

    always_comb begin
        full         = (count_q == CW'(DEPTH));
        empty        = (count_q == '0);
        stored_valid = !empty;
    end

    // PC hold is derived from registered count only, so it never depends
    // on same-cycle fetch or decode handshakes.
    assign pc_update_n = full;
    assign count       = count_q;

    // ------------------------------------------------------------------
    // Output selection (bypass or registered head)
    // ------------------------------------------------------------------
`ifdef FETCH_BUF_BYPASS_EN
    // Forward only while empty; gated by reset_n so out_valid stays low
    // during reset even if in_valid is asserted.
    always_comb begin
        bypass_hit  = reset_n && empty && in_valid && !flush;
        bypass_take = bypass_hit && out_ready;
    end

    always_comb begin
        out_valid = stored_valid || bypass_hit;
        if (bypass_hit) begin
            out_pc    = in_pc;
            out_instr = in_instr;
        end else begin
            out_pc    = pc_mem_q[head_q];
            out_instr = instr_mem_q[head_q];
        end
    end
`else
    always_comb begin
        bypass_hit  = 1'b0;
        bypass_take = 1'b0;
    end

    always_comb begin
        out_valid = stored_valid;
        out_pc    = pc_mem_q[head_q];
        out_instr = instr_mem_q[head_q];
    end
`endif

    // ------------------------------------------------------------------
    // Handshakes
    // ------------------------------------------------------------------
    // A bypassed pair consumed in the same cycle is neither stored nor
    // counted as a pop of stored data; pop only ever retires a stored entry.
    always_comb begin
        push = in_valid && !full && !flush && !bypass_take;
        pop  = stored_valid && out_ready && !flush;
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;

        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push) begin
                tail_d = tail_q + PW'(1);
            end
            if (pop) begin
                head_d = head_q + PW'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CW'(1);
            end else if (pop && !push) begin
                count_d = count_q - CW'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Pointer / count registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // ------------------------------------------------------------------
    // Storage; cleared on reset so outputs are never unknown
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                pc_mem_q[i]    <= '0;
                instr_mem_q[i] <= '0;
            end
        end else if (push) begin
            pc_mem_q[tail_q]    <= in_pc;
            instr_mem_q[tail_q] <= in_instr;
        end
    end

endmodule

// File: tb/tb_fetch_buffer.sv
// ---------------------------------------------------------------------------
// tb_fetch_buffer
//
// Self-checking bench for fetch_buffer (WIDTH=32, DEPTH=4). A table of
// per-cycle vectors drives the main FIFO behaviour; short hand-written
// sequences cover asynchronous reset and the bypass/latency corner.
// Inputs change on the falling edge; outputs are sampled 1 time unit later,
// i.e. before the next rising edge.
// ---------------------------------------------------------------------------
module tb_fetch_buffer;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned DEPTH = 4;

`ifdef FETCH_BUF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic              clk;
    logic              reset_n;
    logic              in_valid;
    logic [WIDTH-1:0]  in_pc;
    logic [31:0]       in_instr;
    logic              pc_update_n;
    logic              flush;
    logic              out_valid;
    logic [WIDTH-1:0]  out_pc;
    logic [31:0]       out_instr;
    logic              out_ready;
    logic [2:0]        count;

    int n_checks = 0;
    int n_fail   = 0;

    fetch_buffer #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .in_valid    (in_valid),
        .in_pc       (in_pc),
        .in_instr    (in_instr),
        .pc_update_n (pc_update_n),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_pc      (out_pc),
        .out_instr   (out_instr),
        .out_ready   (out_ready),
        .count       (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic [31:0] pc;
        logic        fl;
        logic        rdy;
        logic        e_ov;
        logic [31:0] e_pc;
        logic [2:0]  e_cnt;
        logic        e_pun;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic iv, logic [31:0] pc, logic fl, logic rdy,
                                logic e_ov, logic [31:0] e_pc, logic [2:0] e_cnt,
                                logic e_pun);
        vec_t v;
        v.iv = iv; v.pc = pc; v.fl = fl; v.rdy = rdy;
        v.e_ov = e_ov; v.e_pc = e_pc; v.e_cnt = e_cnt; v.e_pun = e_pun;
        return v;
    endfunction

    function automatic logic [31:0] instr_of(logic [31:0] pc);
        return 32'hF000_0000 | pc;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(logic iv, logic [31:0] pc, logic fl, logic rdy);
        in_valid  = iv;
        in_pc     = pc;
        in_instr  = instr_of(pc);
        flush     = fl;
        out_ready = rdy;
    endtask

    initial begin
        // ---------------- vector table ----------------
        // fill 0x0..0xC, fifth pair 0x10 refused
        vecs.push_back(mk(1, 32'h00, 0, 0, 0, 32'h00, 0, 0));
        vecs.push_back(mk(1, 32'h04, 0, 0, 1, 32'h00, 1, 0));
        vecs.push_back(mk(1, 32'h08, 0, 0, 1, 32'h00, 2, 0));
        vecs.push_back(mk(1, 32'h0C, 0, 0, 1, 32'h00, 3, 0));
        vecs.push_back(mk(1, 32'h10, 0, 0, 1, 32'h00, 4, 1));
        // drain in order
        vecs.push_back(mk(0, 32'h00, 0, 1, 1, 32'h00, 4, 1));
        vecs.push_back(mk(0, 32'h00, 0, 1, 1, 32'h04, 3, 0));
        vecs.push_back(mk(0, 32'h00, 0, 1, 1, 32'h08, 2, 0));
        vecs.push_back(mk(0, 32'h00, 0, 1, 1, 32'h0C, 1, 0));
        vecs.push_back(mk(0, 32'h00, 0, 0, 0, 32'h00, 0, 0));
        // steady stream, count stays 1, pointers wrap
        vecs.push_back(mk(1, 32'h20, 0, 0, 0, 32'h00, 0, 0));
        for (int k = 0; k < 10; k++)
            vecs.push_back(mk(1, 32'h24 + 4 * k, 0, 1, 1, 32'h20 + 4 * k, 1, 0));
        vecs.push_back(mk(0, 32'h00, 0, 1, 1, 32'h48, 1, 0));
        vecs.push_back(mk(0, 32'h00, 0, 0, 0, 32'h00, 0, 0));
        // flush at count 3 with incoming 0x40
        vecs.push_back(mk(1, 32'h30, 0, 0, 0, 32'h00, 0, 0));
        vecs.push_back(mk(1, 32'h34, 0, 0, 1, 32'h30, 1, 0));
        vecs.push_back(mk(1, 32'h38, 0, 0, 1, 32'h30, 2, 0));
        vecs.push_back(mk(1, 32'h40, 1, 1, 1, 32'h30, 3, 0));
        vecs.push_back(mk(0, 32'h00, 0, 0, 0, 32'h00, 0, 0));
        vecs.push_back(mk(1, 32'h50, 0, 0, 0, 32'h00, 0, 0));
        vecs.push_back(mk(0, 32'h00, 0, 1, 1, 32'h50, 1, 0));
        vecs.push_back(mk(0, 32'h00, 0, 0, 0, 32'h00, 0, 0));
        // full buffer: push with simultaneous pop is refused
        for (int j = 0; j < 4; j++)
            vecs.push_back(mk(1, 32'h60 + 4 * j, 0, 0, (j > 0), 32'h60, 3'(j), 0));
        vecs.push_back(mk(1, 32'h70, 0, 1, 1, 32'h60, 4, 1));
        vecs.push_back(mk(0, 32'h00, 0, 1, 1, 32'h64, 3, 0));
        vecs.push_back(mk(0, 32'h00, 0, 1, 1, 32'h68, 2, 0));
        vecs.push_back(mk(0, 32'h00, 0, 1, 1, 32'h6C, 1, 0));
        vecs.push_back(mk(0, 32'h00, 0, 0, 0, 32'h00, 0, 0));

        // With bypass, an empty buffer shows the incoming pair immediately.
        // All such rows have out_ready = 0, so storage behaviour is unchanged.
        if (BYP) begin
            foreach (vecs[i]) begin
                if (vecs[i].e_cnt == 0 && vecs[i].iv && !vecs[i].fl) begin
                    vecs[i].e_ov = 1'b1;
                    vecs[i].e_pc = vecs[i].pc;
                end
            end
        end

        // ---------------- reset ----------------
        reset_n = 1'b0;
        drive(0, 32'h0, 0, 0);
        repeat (2) @(negedge clk);
        #1;
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_pc_update_n", 64'(pc_update_n), 64'd0);
        chk("rst_out_pc_known", 64'($isunknown(out_pc) || $isunknown(out_instr)), 64'd0);
        chk("rst_out_pc_zero", 64'(out_pc), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // ---------------- table ----------------
        foreach (vecs[i]) begin
            drive(vecs[i].iv, vecs[i].pc, vecs[i].fl, vecs[i].rdy);
            #1;
            chk($sformatf("v%0d_out_valid", i), 64'(out_valid), 64'(vecs[i].e_ov));
            chk($sformatf("v%0d_count", i), 64'(count), 64'(vecs[i].e_cnt));
            chk($sformatf("v%0d_pc_update_n", i), 64'(pc_update_n), 64'(vecs[i].e_pun));
            if (vecs[i].e_ov) begin
                chk($sformatf("v%0d_out_pc", i), 64'(out_pc), 64'(vecs[i].e_pc));
                chk($sformatf("v%0d_out_instr", i), 64'(out_instr), 64'(instr_of(vecs[i].e_pc)));
            end
            @(negedge clk);
        end

        // ---------------- asynchronous reset mid-stream ----------------
        drive(1, 32'h80, 0, 0);
        @(negedge clk);
        drive(1, 32'h84, 0, 0);
        @(negedge clk);
        drive(0, 32'h0, 0, 0);
        #1;
        chk("pre_arst_count", 64'(count), 64'd2);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_count", 64'(count), 64'd0);
        chk("arst_out_valid", 64'(out_valid), 64'd0);
        chk("arst_out_pc", 64'(out_pc), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        #1;
        chk("post_arst_count", 64'(count), 64'd0);
        chk("post_arst_out_valid", 64'(out_valid), 64'd0);

        // ---------------- bypass / latency at 0x100 ----------------
        drive(1, 32'h100, 0, 1);
        #1;
        if (BYP) begin
            chk("byp_out_valid", 64'(out_valid), 64'd1);
            chk("byp_out_pc", 64'(out_pc), 64'h100);
            chk("byp_out_instr", 64'(out_instr), 64'(instr_of(32'h100)));
        end else begin
            chk("nobyp_out_valid_same", 64'(out_valid), 64'd0);
        end
        chk("byp_count_same", 64'(count), 64'd0);
        @(negedge clk);
        drive(0, 32'h0, 0, 1);
        #1;
        if (BYP) begin
            chk("byp_count_after", 64'(count), 64'd0);
            chk("byp_out_valid_after", 64'(out_valid), 64'd0);
        end else begin
            chk("nobyp_count_after", 64'(count), 64'd1);
            chk("nobyp_out_valid_after", 64'(out_valid), 64'd1);
            chk("nobyp_out_pc_after", 64'(out_pc), 64'h100);
        end
        @(negedge clk);
        drive(0, 32'h0, 0, 0);
        #1;
        chk("final_count", 64'(count), 64'd0);
        chk("final_out_valid", 64'(out_valid), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
